// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl
//   Frame sequencer for the Sobel edge-detector datapath. It accepts a raster pixel
//   stream and drives the line-buffer/window shift enable. After the last source pixel
//   it injects zero-pad shifts to drain the window. It tracks the 3x3 window centre
//   (row, col), flags border centres and latches the per-frame threshold.
//
//   Ports
//     clk, rst               clock, asynchronous active-high reset
//     start_i, thr_cfg_i     frame start; threshold latched when the start is accepted
//     pix_valid_i/ready_o    source pixel handshake
//     shift_en_o, pad_o      datapath shift strobe; pad_o marks a zero-pad (drain) shift
//     out_valid_o/ready_i    centre result handshake (single output register)
//     out_row_o, out_col_o   centre coordinates
//     border_o               centre lies on the image border
//     thr_o                  active threshold
//     busy_o, done_o         frame in progress; one-cycle pulse after the last result
//
//   Build option SOBEL_CTRL_PERF_EN adds stall_cyc_o / frame_cyc_o cycle counters.
module sobel_frame_ctrl #(
    parameter  int               IMG_ROWS = 256,
    parameter  int               IMG_COLS = 256,
    parameter  int               THR_W    = 8,
    parameter  logic [THR_W-1:0] THR_RST  = THR_W'(150),
    localparam int               NPIX     = IMG_ROWS * IMG_COLS,
    localparam int               LAG      = IMG_COLS + 1,
    localparam int               CNT_W    = $clog2(NPIX + LAG + 1),
    localparam int               R_W      = $clog2(IMG_ROWS),
    localparam int               C_W      = $clog2(IMG_COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [THR_W-1:0] thr_cfg_i,
    input  logic             pix_valid_i,
    output logic             pix_ready_o,
    output logic             shift_en_o,
    output logic             pad_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [R_W-1:0]   out_row_o,
    output logic [C_W-1:0]   out_col_o,
    output logic             border_o,
    output logic [THR_W-1:0] thr_o,
    output logic             busy_o,
    output logic             done_o
`ifdef SOBEL_CTRL_PERF_EN
    ,
    output logic [31:0]      stall_cyc_o,
    output logic [31:0]      frame_cyc_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_DRAIN,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(LAG - 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(NPIX - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(NPIX + LAG - 1);
    localparam logic [CNT_W-1:0] LAG_N      = CNT_W'(LAG);
    localparam logic [R_W-1:0]   ROW_LAST   = R_W'(IMG_ROWS - 1);
    localparam logic [C_W-1:0]   COL_LAST   = C_W'(IMG_COLS - 1);

    state_t           state;
    logic [CNT_W-1:0] shift_cnt;
    logic [R_W-1:0]   cen_row;
    logic [C_W-1:0]   cen_col;

    logic can_adv;
    logic src_phase;
    logic drain_phase;
    logic start_acc;
    logic produce;

    // A shift may only happen when the single output register is free or being emptied,
    // because every shift past the fill lag loads a new centre into it.
    assign can_adv     = !out_valid_o || out_ready_i;
    assign src_phase   = (state == S_FILL) || (state == S_RUN);
    assign drain_phase = (state == S_DRAIN);
    assign pix_ready_o = src_phase && can_adv;
    assign shift_en_o  = src_phase ? (pix_valid_i && pix_ready_o) : (drain_phase && can_adv);
    assign pad_o       = drain_phase && can_adv;
    assign start_acc   = start_i && ((state == S_IDLE) || (state == S_DONE));
    // The first LAG shifts only prime the line buffers; later ones complete a window.
    assign produce     = shift_en_o && (shift_cnt >= LAG_N);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            shift_cnt   <= '0;
            cen_row     <= '0;
            cen_col     <= '0;
            out_valid_o <= 1'b0;
            out_row_o   <= '0;
            out_col_o   <= '0;
            border_o    <= 1'b0;
            thr_o       <= THR_RST;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;

            if (shift_en_o) begin
                shift_cnt <= shift_cnt + CNT_W'(1);
            end

            // Centre register: load on a producing shift, otherwise drain on handshake.
            if (produce) begin
                out_valid_o <= 1'b1;
                out_row_o   <= cen_row;
                out_col_o   <= cen_col;
                border_o    <= (cen_row == '0) || (cen_row == ROW_LAST) ||
                               (cen_col == '0) || (cen_col == COL_LAST);
                if (cen_col == COL_LAST) begin
                    cen_col <= '0;
                    cen_row <= cen_row + R_W'(1);
                end else begin
                    cen_col <= cen_col + C_W'(1);
                end
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start_acc) begin
                        state     <= S_FILL;
                        busy_o    <= 1'b1;
                        thr_o     <= thr_cfg_i;
                        shift_cnt <= '0;
                        cen_row   <= '0;
                        cen_col   <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_FILL: begin
                    if (shift_en_o && (shift_cnt == FILL_LAST)) state <= S_RUN;
                end
                S_RUN: begin
                    if (shift_en_o && (shift_cnt == RUN_LAST)) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (shift_en_o && (shift_cnt == DRAIN_LAST)) begin
                        state  <= S_FLUSH;
                        busy_o <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    // Only the final centre can be pending here.
                    if (out_valid_o && out_ready_i) begin
                        state  <= S_DONE;
                        done_o <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SOBEL_CTRL_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cyc_o <= '0;
            frame_cyc_o <= '0;
        end else if (start_acc) begin
            stall_cyc_o <= '0;
            frame_cyc_o <= '0;
        end else begin
            if (busy_o) frame_cyc_o <= sat_inc(frame_cyc_o);
            if (busy_o && out_valid_o && !out_ready_i) stall_cyc_o <= sat_inc(stall_cyc_o);
        end
    end
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
module tb_sobel_frame_ctrl;
    localparam int R    = 4;
    localparam int C    = 4;
    localparam int NPIX = R * C;
    localparam int LAG  = C + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic [7:0] thr_cfg_i = 8'd0;
    logic       pix_valid_i = 1'b0;
    logic       out_ready_i = 1'b0;
    logic       pix_ready_o, shift_en_o, pad_o, out_valid_o, border_o, busy_o, done_o;
    logic [1:0] out_row_o, out_col_o;
    logic [7:0] thr_o;
`ifdef SOBEL_CTRL_PERF_EN
    logic [31:0] stall_cyc_o, frame_cyc_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sobel_frame_ctrl #(.IMG_ROWS(R), .IMG_COLS(C), .THR_W(8), .THR_RST(8'd150)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .thr_cfg_i(thr_cfg_i),
        .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o), .shift_en_o(shift_en_o),
        .pad_o(pad_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_row_o(out_row_o), .out_col_o(out_col_o), .border_o(border_o),
        .thr_o(thr_o), .busy_o(busy_o), .done_o(done_o)
`ifdef SOBEL_CTRL_PERF_EN
        , .stall_cyc_o(stall_cyc_o), .frame_cyc_o(frame_cyc_o)
`endif
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: frame described by counts of source pixels and pads consumed,
    // plus the index of the centre currently held for downstream.
    bit mon_en = 1'b0;
    bit in_frame, m_ov, e_done, frame_done;
    int src_cnt, pad_cnt, m_k, m_thr, fcyc, scyc, cyc;
    int dut_res, dut_pads, dut_dones, sixth_cyc, first_ov_cyc;

    task automatic model_reset();
        in_frame = 0; m_ov = 0; e_done = 0;
        src_cnt = 0; pad_cnt = 0; m_k = 0; m_thr = 150; fcyc = 0; scyc = 0;
    endtask

    always @(negedge clk) begin : monitor
        bit ca, sp, pp, e_rdy, e_sh, e_pd, e_busy, hs, last_hs, was_done, e_bord;
        int n, r, c;
        if (rst) begin
            model_reset();
        end else if (mon_en) begin
            cyc++;
            ca     = !m_ov || out_ready_i;
            sp     = in_frame && (src_cnt < NPIX);
            pp     = in_frame && (src_cnt == NPIX) && (pad_cnt < LAG);
            e_rdy  = sp && ca;
            e_sh   = sp ? (pix_valid_i && e_rdy) : (pp && ca);
            e_pd   = pp && ca;
            e_busy = in_frame && (src_cnt + pad_cnt < NPIX + LAG);

            chk("pix_ready", pix_ready_o, e_rdy);
            chk("shift_en", shift_en_o, e_sh);
            chk("pad", pad_o, e_pd);
            chk("busy", busy_o, e_busy);
            chk("out_valid", out_valid_o, m_ov);
            chk("done", done_o, e_done);
            chk("thr", thr_o, m_thr);
            if (m_ov) begin
                r = m_k / C;
                c = m_k % C;
                e_bord = (r == 0) || (r == R - 1) || (c == 0) || (c == C - 1);
                chk("row", out_row_o, r);
                chk("col", out_col_o, c);
                chk("border", border_o, e_bord);
            end

            if (out_valid_o && out_ready_i) dut_res++;
            if (shift_en_o && pad_o) dut_pads++;
            if (done_o) dut_dones++;
            if (out_valid_o && first_ov_cyc < 0) first_ov_cyc = cyc;

            hs      = m_ov && out_ready_i;
            last_hs = hs && (m_k == NPIX - 1) && in_frame;
            if (e_busy) begin
                fcyc++;
                if (m_ov && !out_ready_i) scyc++;
            end
            if (e_sh) begin
                n = src_cnt + pad_cnt;
                if (n >= LAG) begin
                    m_ov = 1;
                    m_k  = n - LAG;
                end else if (out_ready_i) begin
                    m_ov = 0;
                end
                if (e_pd) pad_cnt++;
                else begin
                    src_cnt++;
                    if (src_cnt == LAG + 1) sixth_cyc = cyc;
                end
            end else if (out_ready_i) begin
                m_ov = 0;
            end
            was_done = e_done;
            e_done   = last_hs;
            if (was_done) begin
                in_frame   = 0;
                frame_done = 1;
            end
            if (start_i && !in_frame) begin
                in_frame = 1; src_cnt = 0; pad_cnt = 0;
                m_thr = thr_cfg_i; fcyc = 0; scyc = 0;
            end
        end
    end

    // vmode: 0 valid always, 1 random 50%. rmode: 0 ready always, 1 toggle,
    // 2 random, 3 ready low for 7 cycles once. At loop cycle 10 a start is
    // pulsed with mid_thr on thr_cfg_i while the frame is busy.
    task automatic run_frame(input logic [7:0] thr, input int vmode, input int rmode,
                             input logic [7:0] mid_thr);
        dut_res = 0; dut_pads = 0; dut_dones = 0; frame_done = 0;
        first_ov_cyc = -1; sixth_cyc = -1;
        @(posedge clk); #1;
        start_i = 1; thr_cfg_i = thr; pix_valid_i = 0; out_ready_i = 1;
        @(posedge clk); #1;
        start_i = 0;
        for (int i = 0; i < 2000 && !frame_done; i++) begin
            pix_valid_i = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            case (rmode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = i[0];
                2:       out_ready_i = 1'($urandom_range(0, 1));
                default: out_ready_i = !(i >= 8 && i < 15);
            endcase
            if (i == 10) begin
                thr_cfg_i = mid_thr;
                start_i   = 1;
            end else begin
                start_i = 0;
            end
            @(posedge clk); #1;
        end
        start_i = 0; pix_valid_i = 0; out_ready_i = 1;
        chk("frame_completed", frame_done, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] thr;
        int         vmode;
        int         rmode;
        logic [7:0] mid;
        int         exp_res;
        int         exp_pads;
        int         exp_done;
        logic [7:0] exp_thr;
    } vec_t;

    vec_t vt[6];

    initial begin : main
        vt[0] = '{8'd150, 0, 0, 8'd10,  16, 5, 1, 8'd150};
        vt[1] = '{8'd100, 0, 1, 8'd11,  16, 5, 1, 8'd100};
        vt[2] = '{8'd120, 1, 0, 8'd12,  16, 5, 1, 8'd120};
        vt[3] = '{8'd90,  0, 0, 8'd200, 16, 5, 1, 8'd90};
        vt[4] = '{8'd200, 1, 2, 8'd7,   16, 5, 1, 8'd200};
        vt[5] = '{8'd33,  0, 3, 8'd44,  16, 5, 1, 8'd33};
        model_reset();
        cyc = 0;

        // Reset state
        #8;
        chk("rst_pix_ready", pix_ready_o, 0);
        chk("rst_shift_en", shift_en_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_row", out_row_o, 0);
        chk("rst_col", out_col_o, 0);
        chk("rst_thr", thr_o, 150);
        #4;
        rst = 0;
        mon_en = 1;

        for (int v = 0; v < 6; v++) begin
            run_frame(vt[v].thr, vt[v].vmode, vt[v].rmode, vt[v].mid);
            chk("results", dut_res, vt[v].exp_res);
            chk("pads", dut_pads, vt[v].exp_pads);
            chk("done_pulses", dut_dones, vt[v].exp_done);
            chk("thr_end", thr_o, vt[v].exp_thr);
            if (vt[v].vmode == 0) chk("first_latency", first_ov_cyc - sixth_cyc, 1);
`ifdef SOBEL_CTRL_PERF_EN
            chk("frame_cyc", frame_cyc_o, fcyc);
            chk("stall_cyc", stall_cyc_o, scyc);
            if (vt[v].rmode == 3) begin
                chk("stall_cyc_7", stall_cyc_o, 7);
                chk("frame_cyc_28", frame_cyc_o, NPIX + LAG + 7);
            end
`endif
        end

        // Asynchronous reset in the middle of a frame
        @(posedge clk); #1;
        start_i = 1; thr_cfg_i = 8'd77; pix_valid_i = 1; out_ready_i = 1;
        @(posedge clk); #1;
        start_i = 0;
        repeat (10) @(posedge clk);
        chk("pre_rst_busy", busy_o, 1);
        #2;
        rst = 1;
        #1;
        chk("arst_pix_ready", pix_ready_o, 0);
        chk("arst_shift_en", shift_en_o, 0);
        chk("arst_pad", pad_o, 0);
        chk("arst_out_valid", out_valid_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_done", done_o, 0);
        chk("arst_row", out_row_o, 0);
        chk("arst_col", out_col_o, 0);
        chk("arst_border", border_o, 0);
        chk("arst_thr", thr_o, 150);
`ifdef SOBEL_CTRL_PERF_EN
        chk("arst_frame_cyc", frame_cyc_o, 0);
        chk("arst_stall_cyc", stall_cyc_o, 0);
`endif
        @(posedge clk); #3;
        rst = 0;
        pix_valid_i = 0;
        run_frame(8'd61, 0, 0, 8'd5);
        chk("post_rst_results", dut_res, 16);
        chk("post_rst_thr", thr_o, 61);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached got=timeout want=finish");
        $fatal(1);
    end
endmodule
